sm83_bus_seq: RTL
=================

SM83_BUS_SEQ -- requirements
Module: sm83_bus_seq

Parameters
REQ-001 SHALL provide parameter ADR_WIDTH, default 16, address bus width.
REQ-002 SHALL provide parameter WORD_SIZE, default 8, data bus width.
REQ-003 SHALL provide parameter MAX_WAIT, default 3, maximum wait states per machine cycle (range 0..15).

Interface
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-005 mread, mwrite, mfetch  in  1 each  request read / write / opcode-fetch cycle; sampled only in T4.
REQ-006 ain  in  ADR_WIDTH  request address; aout  out  ADR_WIDTH  held bus address.
REQ-007 din  in  WORD_SIZE  write data; ext_dout  out  WORD_SIZE  pad output data; ext_oe  out  1  pad output enable.
REQ-008 ext_din  in  WORD_SIZE  pad input data; ext_wait  in  1  wait request from target.
REQ-009 dout  out  WORD_SIZE  captured read data; ctl_zero_data_oe  in  1  forces dout to 0.
REQ-010 rd, wr  out  1 each  active-high strobes; t1, t2, t3, t4, tw  out  1 each  one-hot phase.
REQ-011 busy  out  1  bus cycle in progress; timeout  out  1  sticky wait-limit flag.
REQ-012 opcode  out  WORD_SIZE; bank_cb  out  1; ctl_ir_bank_we, ctl_ir_bank_cb_set  in  1 each.

Function
REQ-013 SHALL run phase sequence T1->T2->T3->T4->T1; exactly one of t1..t4, tw high every cycle.
REQ-014 TW SHALL only be entered from T3 or TW of an active read/write/fetch cycle; idle cycles never enter TW.
REQ-015 In T4, request accepted with priority mwrite > mfetch > mread; aout <= ain, wait counter <= 0, timeout <= 0 on that edge.
REQ-016 Requests asserted outside T4 SHALL be ignored; no request in T4 -> next cycle idle (busy=0, rd=wr=ext_oe=0, aout held).
REQ-017 busy SHALL be 1 during T1..T4 and TW of an accepted cycle.
REQ-018 Read/fetch: rd=1 during T1, T2, T3, TW; rd=0 in T4.
REQ-019 Write: ext_oe=1 during T1..T4 and TW; wr=1 during T2, T3, TW; ext_dout <= din on accept edge, held to end of T4.
REQ-020 In T3 or TW with ext_wait=1 and counter<MAX_WAIT: next phase TW, counter+1; otherwise next phase T4.
REQ-021 Counter reaching MAX_WAIT with ext_wait still 1 SHALL force T4 and set timeout=1 (data still captured); MAX_WAIT=0 disables TW entirely.
REQ-022 Read/fetch data: dout register <= ext_din on the edge leaving T3/TW to T4; value held until next read/fetch capture.
REQ-023 Fetch additionally: opcode <= ext_din on the same edge; read/write never modify opcode.
REQ-024 ctl_zero_data_oe=1 SHALL force dout=0 combinationally without altering the stored register.
REQ-025 ctl_ir_bank_we=1 SHALL load bank_cb <= ctl_ir_bank_cb_set on that edge, any phase.
REQ-026 ext_wait SHALL be ignored outside T3/TW and during idle cycles.

Reset
REQ-027 reset=1 SHALL on that edge: phase <= T1 idle, busy=0, rd=wr=ext_oe=0, aout=0, ext_dout=0, dout=0, opcode=0, bank_cb=0, timeout=0, counter=0.
REQ-028 Reset mid-cycle (including TW) SHALL abort the cycle with no data capture and no opcode update.
REQ-029 Reset SHALL override ctl_ir_bank_we and any request on the same edge.
REQ-030 First request acceptable after reset release is the first T4 (4th cycle after release).

Verification
REQ-031 Read, ain=0xC000, ext_din=0x5A, ext_wait=0 -> rd high T1-T3, dout=0x5A in T4, opcode unchanged, aout=0xC000.
REQ-032 Fetch, ext_din=0xCB, ext_wait=1 for 2 cycles, MAX_WAIT=3 -> T3,TW,TW,T4; opcode=0xCB; timeout=0.
REQ-033 Write, din=0x3C, ext_wait held 1, MAX_WAIT=3 -> 3 TW then T4; wr high T2..TW; ext_dout=0x3C; timeout=1, cleared on next accept.
REQ-034 mread and mwrite together in T4, then mread in T2 -> write cycle executed; T2 request ignored, next cycle idle.
REQ-035 Reset asserted in TW of a read with ext_din=0x77 -> dout=0, phase T1 idle, busy=0 next cycle.
REQ-036 ctl_zero_data_oe=1 after read of 0x99 -> dout=0; deasserted -> dout=0x99.

Source files
------------

// File: rtl/sm83_bus_seq_if.sv
// sm83_bus_seq_if -- bundle of request, pad and control signals around the
// SM83 machine-cycle sequencer.
//
//   master modport : the requesting core / testbench side (drives requests,
//                    pad input data, wait line and IR-bank controls)
//   slave modport  : the sequencer itself (drives address, strobes, phase
//                    flags, captured data, opcode and status)
//
// Signals
//   mread/mwrite/mfetch   cycle requests, sampled only in T4
//   ain / aout            request address / held bus address
//   din / ext_dout/ext_oe write data / pad output data and enable
//   ext_din / ext_wait    pad input data / wait request from target
//   dout                  captured read data (forced 0 by ctl_zero_data_oe)
//   rd / wr               active-high bus strobes
//   t1..t4 / tw           one-hot machine-cycle phase
//   busy / timeout        cycle in progress / sticky wait-limit flag
//   opcode / bank_cb      last fetched opcode / CB-prefix bank flag
interface sm83_bus_seq_if #(
   parameter int ADR_WIDTH = 16,
   parameter int WORD_SIZE = 8
);
   logic                 mread;
   logic                 mwrite;
   logic                 mfetch;
   logic [ADR_WIDTH-1:0] ain;
   logic [ADR_WIDTH-1:0] aout;
   logic [WORD_SIZE-1:0] din;
   logic [WORD_SIZE-1:0] ext_dout;
   logic                 ext_oe;
   logic [WORD_SIZE-1:0] ext_din;
   logic                 ext_wait;
   logic [WORD_SIZE-1:0] dout;
   logic                 ctl_zero_data_oe;
   logic                 rd;
   logic                 wr;
   logic                 t1;
   logic                 t2;
   logic                 t3;
   logic                 t4;
   logic                 tw;
   logic                 busy;
   logic                 timeout;
   logic [WORD_SIZE-1:0] opcode;
   logic                 bank_cb;
   logic                 ctl_ir_bank_we;
   logic                 ctl_ir_bank_cb_set;

   modport master (
      output mread, mwrite, mfetch, ain, din, ext_din, ext_wait,
             ctl_zero_data_oe, ctl_ir_bank_we, ctl_ir_bank_cb_set,
      input  aout, ext_dout, ext_oe, dout, rd, wr, t1, t2, t3, t4, tw,
             busy, timeout, opcode, bank_cb
   );

   modport slave (
      input  mread, mwrite, mfetch, ain, din, ext_din, ext_wait,
             ctl_zero_data_oe, ctl_ir_bank_we, ctl_ir_bank_cb_set,
      output aout, ext_dout, ext_oe, dout, rd, wr, t1, t2, t3, t4, tw,
             busy, timeout, opcode, bank_cb
   );
endinterface

// File: rtl/sm83_bus_seq.sv
// sm83_bus_seq -- SM83 machine-cycle bus sequencer.
//
// Runs a free-running T1->T2->T3->T4 phase ring. In T4 a new read, write or
// opcode-fetch cycle is accepted (write > fetch > read); the accepted cycle
// occupies the following T1..T4, stretched by up to MAX_WAIT wait states
// (TW) while the target holds ext_wait in T3/TW. Read/fetch data is captured
// on the edge that leaves T3/TW for T4.
//
// Ports
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    sm83_bus_seq_if.slave (requests, pad signals, phase/status)
module sm83_bus_seq #(
   parameter int ADR_WIDTH = 16,
   parameter int WORD_SIZE = 8,
   parameter int MAX_WAIT  = 3
) (
   input  logic           clk,
   input  logic           reset,
   sm83_bus_seq_if.slave  bus
);

   // One-hot phase, bit order {tw, t4, t3, t2, t1}
   localparam logic [4:0] PH_T1 = 5'b00001;
   localparam logic [4:0] PH_T2 = 5'b00010;
   localparam logic [4:0] PH_T3 = 5'b00100;
   localparam logic [4:0] PH_T4 = 5'b01000;
   localparam logic [4:0] PH_TW = 5'b10000;

   // Kind of machine cycle currently on the bus
   localparam logic [1:0] CYC_IDLE  = 2'd0;
   localparam logic [1:0] CYC_READ  = 2'd1;
   localparam logic [1:0] CYC_WRITE = 2'd2;
   localparam logic [1:0] CYC_FETCH = 2'd3;

   localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

   logic [4:0]           phase_reg;
   logic [1:0]           cyc_reg;
   logic [3:0]           wait_cnt_reg;
   logic                 timeout_reg;
   logic [ADR_WIDTH-1:0] aout_reg;
   logic [WORD_SIZE-1:0] ext_dout_reg;
   logic [WORD_SIZE-1:0] dout_reg;
   logic [WORD_SIZE-1:0] opcode_reg;
   logic                 bank_cb_reg;

   logic active;
   logic reads;
   logic writes;

   assign active = (cyc_reg != CYC_IDLE);
   assign reads  = (cyc_reg == CYC_READ) || (cyc_reg == CYC_FETCH);
   assign writes = (cyc_reg == CYC_WRITE);

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_reg    <= PH_T1;
         cyc_reg      <= CYC_IDLE;
         wait_cnt_reg <= '0;
         timeout_reg  <= 1'b0;
         aout_reg     <= '0;
         ext_dout_reg <= '0;
         dout_reg     <= '0;
         opcode_reg   <= '0;
         bank_cb_reg  <= 1'b0;
      end else begin
         if (bus.ctl_ir_bank_we) begin
            bank_cb_reg <= bus.ctl_ir_bank_cb_set;
         end

         case (phase_reg)
            PH_T1: phase_reg <= PH_T2;
            PH_T2: phase_reg <= PH_T3;
            PH_T3, PH_TW: begin
               // Idle cycles ignore ext_wait so they never stretch.
               if (active && bus.ext_wait && (wait_cnt_reg < MAX_W)) begin
                  phase_reg    <= PH_TW;
                  wait_cnt_reg <= wait_cnt_reg + 4'd1;
               end else begin
                  phase_reg <= PH_T4;
                  // Wait limit hit with the target still stalling: the cycle
                  // is forced to finish and the data on the pads is taken.
                  if (active && bus.ext_wait) begin
                     timeout_reg <= 1'b1;
                  end
                  if (reads) begin
                     dout_reg <= bus.ext_din;
                  end
                  if (cyc_reg == CYC_FETCH) begin
                     opcode_reg <= bus.ext_din;
                  end
               end
            end
            PH_T4: begin
               phase_reg <= PH_T1;
               if (bus.mwrite || bus.mfetch || bus.mread) begin
                  aout_reg     <= bus.ain;
                  wait_cnt_reg <= '0;
                  timeout_reg  <= 1'b0;
               end
               if (bus.mwrite) begin
                  cyc_reg      <= CYC_WRITE;
                  ext_dout_reg <= bus.din;
               end else if (bus.mfetch) begin
                  cyc_reg <= CYC_FETCH;
               end else if (bus.mread) begin
                  cyc_reg <= CYC_READ;
               end else begin
                  cyc_reg <= CYC_IDLE;
               end
            end
            default: begin
               phase_reg <= PH_T1;
               cyc_reg   <= CYC_IDLE;
            end
         endcase
      end
   end

   assign bus.t1 = phase_reg[0];
   assign bus.t2 = phase_reg[1];
   assign bus.t3 = phase_reg[2];
   assign bus.t4 = phase_reg[3];
   assign bus.tw = phase_reg[4];

   assign bus.busy     = active;
   assign bus.rd       = reads && !phase_reg[3];
   assign bus.wr       = writes && (phase_reg[1] || phase_reg[2] || phase_reg[4]);
   assign bus.ext_oe   = writes;
   assign bus.ext_dout = ext_dout_reg;
   assign bus.aout     = aout_reg;
   assign bus.timeout  = timeout_reg;
   assign bus.opcode   = opcode_reg;
   assign bus.bank_cb  = bank_cb_reg;

   // Zero-forcing acts on the output only; the captured value survives.
   genvar gi;
   generate
      for (gi = 0; gi < WORD_SIZE; gi++) begin : g_dout
         assign bus.dout[gi] = dout_reg[gi] & ~bus.ctl_zero_data_oe;
      end
   endgenerate

endmodule
